// File: rtl/cnnip_pkg.sv
// Shared CNN IP definitions: default memory geometry, the stream reader FSM
// state encoding and the reader skid FIFO depth.
package cnnip_pkg;

  localparam int CNNIP_ADDR_W      = 12;
  localparam int CNNIP_DATA_W      = 32;
  localparam int READER_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_fifo_d4.sv
// 4-entry synchronous FIFO used as the reader's output buffer.
//   clk_i   : clock          rst_i   : synchronous active-high reset
//   push_i  : write din_i    pop_i   : remove head (ignored when empty)
//   dout_o  : head entry     count_o : occupancy 0..4   empty_o : count==0
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_d4
  import cnnip_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [2:0]   count_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [READER_FIFO_DEPTH];
  logic [1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != 3'd0);
    do_push = push_i && ((cnt_q != 3'(READER_FIFO_DEPTH)) || do_pop);
    wr_d    = do_push ? wr_q + 2'd1 : wr_q;
    rd_d    = do_pop  ? rd_q + 2'd1 : rd_q;
    cnt_d   = cnt_q + {2'b00, do_push} - {2'b00, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is pure datapath; the head is masked by the consumer when empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == 3'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side DMA stage behind BRAM port B. A start command latches a word
// window; single-word reads are issued in order, the one-cycle BRAM latency
// is absorbed into a 4-entry FIFO, and words leave as a valid/ready stream
// with m_last on the final word.
//   clk_a, srst_aq             : clock, synchronous active-high reset
//   start, base_addr, len      : command (len 0..4096, sampled in IDLE)
//   busy, done                 : status; done pulses one cycle at completion
//   mem_en/we/addr/din/dout    : BRAM port (write side tied off)
//   m_valid/m_ready/m_data/m_last : output stream
module bram_stream_reader
  import cnnip_pkg::*;
#(
  parameter int ADDR_W = CNNIP_ADDR_W,
  parameter int DATA_W = CNNIP_DATA_W
) (
  input  logic              clk_a,
  input  logic              srst_aq,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;
  logic              issue, credit_ok, pop, final_read;
  logic [3:0]        occ;
  logic [2:0]        fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;

  // A read is only issued when its data is guaranteed a FIFO slot even if
  // the consumer never pops: buffered words plus the one in flight.
  assign occ        = {1'b0, fifo_count} + {3'b000, inflight_q};
  assign credit_ok  = occ < 4'(READER_FIFO_DEPTH);
  assign final_read = (rem_q == {{ADDR_W{1'b0}}, 1'b1});
  assign pop        = m_valid && m_ready;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    issue           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ST_RUN;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;  // wraps modulo 2^ADDR_W
          rem_d  = rem_q - 1'b1;
          if (final_read) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && final_read;
  end

  always_ff @(posedge clk_a) begin
    if (srst_aq) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  sync_fifo_d4 #(.W(DATA_W + 1)) u_fifo (
    .clk_i   (clk_a),
    .rst_i   (srst_aq),
    .push_i  (inflight_q),
    .din_i   ({inflight_last_q, mem_dout}),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign mem_din  = '0;
  assign m_valid  = !fifo_empty;
  // Mask the head so idle/reset outputs read as zero.
  assign m_data   = m_valid ? fifo_head[DATA_W-1:0] : '0;
  assign m_last   = m_valid && fifo_head[DATA_W];

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk_a = 1'b0;
  logic          srst_aq = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, mem_en, mem_we, m_valid, m_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, m_data;
  logic [DW-1:0] mem_dout = '0;
  logic          m_ready = 1'b1;

  bram_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_a(clk_a), .srst_aq(srst_aq), .start(start), .base_addr(base_addr),
    .len(len), .busy(busy), .done(done), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk_a = ~clk_a;

  // Behavioural BRAM port B: preloaded mem[i] = 0x100 + i, 1-cycle read.
  logic [DW-1:0] bram [1 << AW];
  initial for (int i = 0; i < (1 << AW); i++) bram[i] = 32'h100 + i;
  always @(posedge clk_a) if (mem_en && !mem_we) mem_dout <= bram[mem_addr];

  typedef struct { logic [DW-1:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int rd_cnt = 0, hs_cnt = 0, first_hs = 0, last_hs = 0;
  logic [AW-1:0] exp_addr = '0;
  int rdy_mode = 0;  // 0: held high, 1: random, 2: held low

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_a) cyc <= cyc + 1;

  always @(posedge clk_a) begin
    #1;
    case (rdy_mode)
      1:       m_ready = 1'($urandom_range(0, 1));
      2:       m_ready = 1'b0;
      default: m_ready = 1'b1;
    endcase
  end

  // Monitor: read order, stream scoreboard, stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk_a) begin
    if (srst_aq) begin
      prev_stall = 1'b0;
    end else begin
      chk("mem_we_zero", {63'd0, mem_we}, 64'd0);
      chk("mem_din_zero", {32'd0, mem_din}, 64'd0);
      if (mem_en) begin
        chk("rd_addr", {52'd0, mem_addr}, {52'd0, exp_addr});
        exp_addr = exp_addr + 1'b1;
        rd_cnt++;
      end
      if (prev_stall) begin
        chk("valid_held", {63'd0, m_valid}, 64'd1);
        chk("data_held", {32'd0, m_data}, {32'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_data", {32'd0, m_data}, {32'd0, e.data});
          chk("beat_last", {63'd0, m_last}, {63'd0, e.last});
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk_a); #1;
  endtask

  // Issue a command; the reference model enqueues the words the window holds.
  task automatic do_start(input logic [AW-1:0] b, input int l);
    start = 1'b1; base_addr = b; len = (AW+1)'(l);
    exp_addr = b; rd_cnt = 0; hs_cnt = 0;
    for (int k = 0; k < l; k++) begin
      exp_t e;
      e.data = 32'h100 + ((int'(b) + k) % (1 << AW));
      e.last = (k == l - 1);
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int got = 0;
    for (int n = 0; n < maxc; n++) begin
      if (done) begin got = 1; break; end
      tick();
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got != 0) begin
      chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
      chk({nm, "_done_lat"}, 64'(cyc), 64'(last_hs + 1));
      chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    chk({nm, "_done"}, {63'd0, done}, 64'd0);
    chk({nm, "_mem_en"}, {63'd0, mem_en}, 64'd0);
    chk({nm, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    chk({nm, "_m_last"}, {63'd0, m_last}, 64'd0);
    chk({nm, "_mem_addr"}, {52'd0, mem_addr}, 64'd0);
    chk({nm, "_m_data"}, {32'd0, m_data}, 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    srst_aq = 1'b0;
    tick();

    // 1. Basic transfer with latency checks.
    rdy_mode = 0;
    do_start(12'h010, 3);
    chk("t1_busy_c1", {63'd0, busy}, 64'd1);
    chk("t1_en_c1", {63'd0, mem_en}, 64'd1);
    chk("t1_addr_c1", {52'd0, mem_addr}, 64'h010);
    tick();
    chk("t1_valid_c2", {63'd0, m_valid}, 64'd0);
    tick();
    chk("t1_valid_c3", {63'd0, m_valid}, 64'd1);
    wait_done("t1", 50);
    chk("t1_reads", 64'(rd_cnt), 64'd3);

    // 2. Backpressure; this start lands in the done cycle of test 1.
    rdy_mode = 2; m_ready = 1'b0;
    do_start(12'h000, 8);
    repeat (12) tick();
    chk("t2_reads_stalled", 64'(rd_cnt), 64'd4);
    chk("t2_no_beats", 64'(hs_cnt), 64'd0);
    chk("t2_valid_held", {63'd0, m_valid}, 64'd1);
    rdy_mode = 0; m_ready = 1'b1;
    wait_done("t2", 100);
    chk("t2_beats", 64'(hs_cnt), 64'd8);
    chk("t2_no_gaps", 64'(last_hs - first_hs), 64'd7);
    chk("t2_reads", 64'(rd_cnt), 64'd8);

    // 3. Wrap and full window.
    tick();
    do_start(12'hFFE, 4);
    wait_done("t3_wrap", 50);
    chk("t3_wrap_reads", 64'(rd_cnt), 64'd4);
    tick();
    do_start(12'($urandom), 4096);
    wait_done("t3_full", 5000);
    chk("t3_full_reads", 64'(rd_cnt), 64'd4096);
    chk("t3_full_beats", 64'(hs_cnt), 64'd4096);

    // 4. Zero length, then ignored start during a transfer.
    tick();
    do_start(12'h055, 0);
    chk("t4_zero_done", {63'd0, done}, 64'd1);
    chk("t4_zero_busy", {63'd0, busy}, 64'd0);
    chk("t4_zero_en", {63'd0, mem_en}, 64'd0);
    tick();
    chk("t4_zero_reads", 64'(rd_cnt), 64'd0);
    chk("t4_zero_done_pulse", {63'd0, done}, 64'd0);
    do_start(12'h020, 5);
    tick(); tick();
    start = 1'b1; base_addr = 12'h300; len = 13'd9;
    tick();
    start = 1'b0;
    wait_done("t4_ign", 100);
    chk("t4_ign_reads", 64'(rd_cnt), 64'd5);
    chk("t4_ign_beats", 64'(hs_cnt), 64'd5);

    // 5. Reset mid-operation.
    tick();
    do_start(12'h000, 6);
    tick();
    srst_aq = 1'b1;
    tick();
    srst_aq = 1'b0;
    chk_all_zero("t5_after_rst");
    exp_q.delete();
    begin
      int saw_done = 0;
      for (int n = 0; n < 10; n++) begin
        if (done || m_valid || mem_en) saw_done = 1;
        tick();
      end
      chk("t5_quiet_after_rst", 64'(saw_done), 64'd0);
    end
    do_start(12'h000, 2);
    wait_done("t5_fresh", 50);
    chk("t5_fresh_reads", 64'(rd_cnt), 64'd2);

    // Randomized windows with random backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int l;
      tick();
      l = $urandom_range(1, 40);
      do_start(12'($urandom), l);
      wait_done("rand", 2000);
      chk("rand_reads", 64'(rd_cnt), 64'(l));
      chk("rand_beats", 64'(hs_cnt), 64'(l));
    end
    rdy_mode = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
